// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame collector.
// No logic; state encoding and pixel width live here.
// Imported by the collector and its frame RAM.
package pixel_pkg;

  localparam int              PIX_W   = 8;
  localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

  typedef enum logic {
    CAPTURE = 1'b0,
    DRAIN   = 1'b1
  } state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one synchronous read port.
// Latency: read data appears one cycle after rd_en; held while rd_en is low.
// Backpressure: none; the caller gates rd_en to stall the read data.
module frame_ram
  import pixel_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Write port: store a pixel when the collector accepts a beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered output that holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pixel_frame_collector.sv
// Captures one raster frame into RAM with a running XOR, then replays it with raster flags.
// Latency: first output beat two cycles after the last input beat; one beat/cycle both ways.
// Backpressure: in_ready is high only while capturing; out_ready low freezes the output beat.
module pixel_frame_collector
  import pixel_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_abort,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_byte,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_byte,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_sol,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done,
  output logic [PIX_W-1:0] frame_xor
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);

  state_t           state;
  state_t           next_state;

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [AW-1:0]    wr_addr;
  logic [PIX_W-1:0] run_xor;

  logic [AW-1:0]    rd_ptr;
  logic [XW-1:0]    rd_x;
  logic             rd_last;   // final address already fetched this drain

  logic             in_beat;
  logic             last_in;
  logic             out_hs;
  logic             eof_hs;
  logic             fetch;

  // An abort in the same cycle as an input beat drops the beat entirely.
  assign in_beat = in_valid && (state == CAPTURE) && !frame_abort;
  assign last_in = in_beat && (x == X_LAST) && (y == Y_LAST);
  assign out_hs  = out_valid && out_ready;
  assign eof_hs  = out_hs && out_eof;
  // Read the next pixel whenever the output register is empty or being emptied.
  assign fetch   = (state == DRAIN) && !rd_last && (!out_valid || out_ready) && !frame_abort;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CAPTURE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: capture until the last pixel lands, drain until the eof beat leaves.
  always_comb begin
    next_state = state;
    if (frame_abort) begin
      next_state = CAPTURE;
    end else begin
      case (state)
        CAPTURE: if (last_in) next_state = DRAIN;
        DRAIN:   if (eof_hs)  next_state = CAPTURE;
        default: next_state = CAPTURE;
      endcase
    end
  end

  // State-decoded outputs: input is accepted only while capturing.
  always_comb begin
    in_ready = (state == CAPTURE);
  end

  // Capture counters and running checksum.
  always_ff @(posedge clk) begin
    if (rst || frame_abort) begin
      x       <= '0;
      y       <= '0;
      wr_addr <= '0;
      run_xor <= '0;
    end else if (in_beat) begin
      if (last_in) begin
        x       <= '0;
        y       <= '0;
        wr_addr <= '0;
        run_xor <= '0;
      end else begin
        run_xor <= run_xor ^ in_byte;
        wr_addr <= wr_addr + AW'(1);
        if (x == X_LAST) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  // Completion pulse and frame checksum; abort leaves the last checksum intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_xor  <= '0;
    end else begin
      frame_done <= last_in;
      if (last_in) begin
        frame_xor <= run_xor ^ in_byte;
      end
    end
  end

  // Read pointer and its column, walked in raster order during drain.
  always_ff @(posedge clk) begin
    if (rst || frame_abort || eof_hs) begin
      rd_ptr  <= '0;
      rd_x    <= '0;
      rd_last <= 1'b0;
    end else if (fetch) begin
      if (rd_ptr == A_LAST) begin
        rd_ptr  <= '0;
        rd_x    <= '0;
        rd_last <= 1'b1;
      end else begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_x   <= (rd_x == X_LAST) ? '0 : rd_x + XW'(1);
      end
    end
  end

  // Output valid and flags, registered alongside the RAM read data.
  always_ff @(posedge clk) begin
    if (rst || frame_abort) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (fetch) begin
      out_valid <= 1'b1;
      out_sof   <= (rd_ptr == '0);
      out_sol   <= (rd_x == '0);
      out_eol   <= (rd_x == X_LAST);
      out_eof   <= (rd_ptr == A_LAST);
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

  frame_ram #(
    .DEPTH (N)
  ) u_frame_ram (
    .clk     (clk),
    .wr_en   (in_beat),
    .wr_addr (wr_addr),
    .wr_data (in_byte),
    .rd_en   (fetch),
    .rd_addr (rd_ptr),
    .rd_data (out_byte)
  );

endmodule
